// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, CDB write-back, in-order retire.
// Optional retire counter port enabled by ROB_COMMIT_COUNTER_EN.
module rob_commit #(
  parameter int ROB_IDX_WIDTH  = 4,
  parameter int INSTR_ID_WIDTH = 6,
  parameter int WORD_WIDTH     = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      issue_to_rob_en_in,
  input  logic [INSTR_ID_WIDTH-1:0] issue_to_rob_instr_id_in,
  input  logic [4:0]                issue_to_rob_rd_in,
  input  logic                      issue_to_rob_is_store_in,
  input  logic                      issue_to_rob_is_branch_in,
  input  logic                      issue_to_rob_pred_jump_in,
  output logic [ROB_IDX_WIDTH-1:0]  rob_tail_pos_out,
  output logic                      rob_full_out,
  input  logic [ROB_IDX_WIDTH-1:0]  query_rs1_pos_in,
  input  logic [ROB_IDX_WIDTH-1:0]  query_rs2_pos_in,
  output logic                      query_rs1_ready_out,
  output logic                      query_rs2_ready_out,
  output logic [WORD_WIDTH-1:0]     query_rs1_res_out,
  output logic [WORD_WIDTH-1:0]     query_rs2_res_out,
  input  logic                      cdb_en_in,
  input  logic [ROB_IDX_WIDTH-1:0]  cdb_rob_pos_in,
  input  logic [WORD_WIDTH-1:0]     cdb_res_in,
  input  logic                      cdb_jump_in,
  input  logic [WORD_WIDTH-1:0]     cdb_target_pc_in,
  output logic                      commit_to_regfile_en_out,
  output logic [INSTR_ID_WIDTH-1:0] commit_to_regfile_instr_id_out,
  output logic [4:0]                commit_to_regfile_rd_out,
  output logic [ROB_IDX_WIDTH-1:0]  commit_to_regfile_rob_pos_out,
  output logic [WORD_WIDTH-1:0]     commit_to_regfile_res_out,
  output logic                      commit_to_lsb_en_out,
  output logic [ROB_IDX_WIDTH-1:0]  commit_to_lsb_rob_pos_out,
  output logic                      clear_branch_out,
  output logic [WORD_WIDTH-1:0]     jump_pc_out
`ifdef ROB_COMMIT_COUNTER_EN
  ,
  output logic [31:0]               retired_cnt_out
`endif
);

  localparam int ROB_SIZE = 2 ** ROB_IDX_WIDTH;

  typedef logic [ROB_IDX_WIDTH-1:0] idx_t;

  logic [ROB_SIZE-1:0]       busy_q;
  logic [ROB_SIZE-1:0]       ready_q;
  logic [ROB_SIZE-1:0]       store_q;
  logic [ROB_SIZE-1:0]       branch_q;
  logic [ROB_SIZE-1:0]       pred_q;
  logic [ROB_SIZE-1:0]       jump_q;
  logic [WORD_WIDTH-1:0]     res_q    [ROB_SIZE];
  logic [WORD_WIDTH-1:0]     target_q [ROB_SIZE];
  logic [4:0]                rd_q     [ROB_SIZE];
  logic [INSTR_ID_WIDTH-1:0] id_q     [ROB_SIZE];

  idx_t head_q;
  idx_t tail_q;
  idx_t count_q;

  logic alloc;
  logic do_commit;
  logic mispredict;
  logic cdb_hit;

  // Slot 0 means "no producer", so pointers wrap past it.
  function automatic idx_t nxt(input idx_t p);
    return (p == idx_t'(ROB_SIZE - 1)) ? idx_t'(1) : p + idx_t'(1);
  endfunction

  // Handshake decode and operand lookup.
  always_comb begin
    rob_full_out        = (count_q == idx_t'(ROB_SIZE - 1));
    rob_tail_pos_out    = tail_q;
    alloc               = issue_to_rob_en_in && !rob_full_out;
    do_commit           = busy_q[head_q] && ready_q[head_q];
    mispredict          = do_commit && branch_q[head_q] &&
                          (jump_q[head_q] != pred_q[head_q]);
    cdb_hit             = cdb_en_in && (cdb_rob_pos_in != '0) &&
                          busy_q[cdb_rob_pos_in];
    query_rs1_ready_out = (query_rs1_pos_in != '0) &&
                          busy_q[query_rs1_pos_in] &&
                          ready_q[query_rs1_pos_in];
    query_rs2_ready_out = (query_rs2_pos_in != '0) &&
                          busy_q[query_rs2_pos_in] &&
                          ready_q[query_rs2_pos_in];
    query_rs1_res_out   = res_q[query_rs1_pos_in];
    query_rs2_res_out   = res_q[query_rs2_pos_in];
  end

  // Entry table, pointers and registered retire outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q                         <= '0;
      ready_q                        <= '0;
      head_q                         <= idx_t'(1);
      tail_q                         <= idx_t'(1);
      count_q                        <= '0;
      commit_to_regfile_en_out       <= 1'b0;
      commit_to_regfile_instr_id_out <= '0;
      commit_to_regfile_rd_out       <= '0;
      commit_to_regfile_rob_pos_out  <= '0;
      commit_to_regfile_res_out      <= '0;
      commit_to_lsb_en_out           <= 1'b0;
      commit_to_lsb_rob_pos_out      <= '0;
      clear_branch_out               <= 1'b0;
      jump_pc_out                    <= '0;
    end else if (rdy_in) begin
      commit_to_regfile_en_out <= do_commit;
      commit_to_lsb_en_out     <= do_commit && store_q[head_q];
      clear_branch_out         <= mispredict;
      if (do_commit) begin
        commit_to_regfile_instr_id_out <= id_q[head_q];
        commit_to_regfile_rd_out       <= rd_q[head_q];
        commit_to_regfile_rob_pos_out  <= head_q;
        commit_to_regfile_res_out      <= res_q[head_q];
        commit_to_lsb_rob_pos_out      <= head_q;
      end
      if (mispredict) begin
        jump_pc_out <= target_q[head_q];
        busy_q      <= '0;
        head_q      <= idx_t'(1);
        tail_q      <= idx_t'(1);
        count_q     <= '0;
      end else begin
        if (cdb_hit) begin
          ready_q[cdb_rob_pos_in]  <= 1'b1;
          res_q[cdb_rob_pos_in]    <= cdb_res_in;
          jump_q[cdb_rob_pos_in]   <= cdb_jump_in;
          target_q[cdb_rob_pos_in] <= cdb_target_pc_in;
        end
        if (alloc) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= issue_to_rob_is_store_in;
          store_q[tail_q]  <= issue_to_rob_is_store_in;
          branch_q[tail_q] <= issue_to_rob_is_branch_in;
          pred_q[tail_q]   <= issue_to_rob_pred_jump_in;
          jump_q[tail_q]   <= 1'b0;
          res_q[tail_q]    <= '0;
          target_q[tail_q] <= '0;
          rd_q[tail_q]     <= issue_to_rob_rd_in;
          id_q[tail_q]     <= issue_to_rob_instr_id_in;
          tail_q           <= nxt(tail_q);
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= nxt(head_q);
        end
        if (alloc && !do_commit) begin
          count_q <= count_q + idx_t'(1);
        end else if (!alloc && do_commit) begin
          count_q <= count_q - idx_t'(1);
        end
      end
    end
  end

`ifdef ROB_COMMIT_COUNTER_EN
  // Retired instruction count; survives flushes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      retired_cnt_out <= '0;
    end else if (rdy_in && do_commit) begin
      retired_cnt_out <= retired_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus randomized traffic
// against a queue-based program-order model.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        iss_en, iss_st, iss_br, iss_pred;
  logic [5:0]  iss_id;
  logic [4:0]  iss_rd;
  logic [3:0]  tail_pos;
  logic        full;
  logic [3:0]  q1, q2;
  logic        q1_rdy, q2_rdy;
  logic [31:0] q1_res, q2_res;
  logic        cdb_en, cdb_jump;
  logic [3:0]  cdb_pos;
  logic [31:0] cdb_res, cdb_tgt;
  logic        c_en;
  logic [5:0]  c_id;
  logic [4:0]  c_rd;
  logic [3:0]  c_pos;
  logic [31:0] c_res;
  logic        l_en;
  logic [3:0]  l_pos;
  logic        clr;
  logic [31:0] jpc;

  int nt = 0;
  int nf = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk_in                         (clk),
    .rst_in                         (rst),
    .rdy_in                         (rdy),
    .issue_to_rob_en_in             (iss_en),
    .issue_to_rob_instr_id_in       (iss_id),
    .issue_to_rob_rd_in             (iss_rd),
    .issue_to_rob_is_store_in       (iss_st),
    .issue_to_rob_is_branch_in      (iss_br),
    .issue_to_rob_pred_jump_in      (iss_pred),
    .rob_tail_pos_out               (tail_pos),
    .rob_full_out                   (full),
    .query_rs1_pos_in               (q1),
    .query_rs2_pos_in               (q2),
    .query_rs1_ready_out            (q1_rdy),
    .query_rs2_ready_out            (q2_rdy),
    .query_rs1_res_out              (q1_res),
    .query_rs2_res_out              (q2_res),
    .cdb_en_in                      (cdb_en),
    .cdb_rob_pos_in                 (cdb_pos),
    .cdb_res_in                     (cdb_res),
    .cdb_jump_in                    (cdb_jump),
    .cdb_target_pc_in               (cdb_tgt),
    .commit_to_regfile_en_out       (c_en),
    .commit_to_regfile_instr_id_out (c_id),
    .commit_to_regfile_rd_out       (c_rd),
    .commit_to_regfile_rob_pos_out  (c_pos),
    .commit_to_regfile_res_out      (c_res),
    .commit_to_lsb_en_out           (l_en),
    .commit_to_lsb_rob_pos_out      (l_pos),
    .clear_branch_out               (clr),
    .jump_pc_out                    (jpc)
  );

  typedef struct {
    int          pos;
    logic [5:0]  id;
    logic [4:0]  rd;
    bit          st, br, pred, done, jmp;
    logic [31:0] res, tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail = 1;
  bit          e_en, e_lsb, e_clr;
  logic [5:0]  e_id;
  logic [4:0]  e_rd;
  logic [3:0]  e_pos, e_lsbpos;
  logic [31:0] e_res, e_jpc;

  // Program-order model: advance one clock edge from current inputs.
  task automatic model_edge();
    bit   mfull, com, mis;
    ent_t n;
    if (rst) begin
      mq.delete();
      m_tail = 1;
      e_en = 0; e_lsb = 0; e_clr = 0; e_id = 0; e_rd = 0;
      e_pos = 0; e_res = 0; e_lsbpos = 0; e_jpc = 0;
    end else if (rdy) begin
      mfull = (mq.size() == 15);
      com   = (mq.size() > 0) && mq[0].done;
      mis   = com && mq[0].br && (mq[0].jmp != mq[0].pred);
      e_en  = com;
      e_lsb = com && mq[0].st;
      e_clr = mis;
      if (com) begin
        e_id     = mq[0].id;
        e_rd     = mq[0].rd;
        e_pos    = 4'(mq[0].pos);
        e_lsbpos = 4'(mq[0].pos);
        e_res    = mq[0].res;
      end
      if (mis) begin
        e_jpc = mq[0].tgt;
        mq.delete();
        m_tail = 1;
      end else begin
        if (cdb_en) begin
          foreach (mq[k]) begin
            if (mq[k].pos == int'(cdb_pos)) begin
              mq[k].done = 1;
              mq[k].res  = cdb_res;
              mq[k].jmp  = cdb_jump;
              mq[k].tgt  = cdb_tgt;
            end
          end
        end
        if (com) void'(mq.pop_front());
        if (iss_en && !mfull) begin
          n.pos = m_tail; n.id = iss_id; n.rd = iss_rd;
          n.st = iss_st; n.br = iss_br; n.pred = iss_pred;
          n.done = iss_st; n.jmp = 0; n.res = 0; n.tgt = 0;
          mq.push_back(n);
          m_tail = (m_tail % 15) + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1;
    iss_en = 0; iss_id = 0; iss_rd = 0;
    iss_st = 0; iss_br = 0; iss_pred = 0;
    q1 = 0; q2 = 0;
    cdb_en = 0; cdb_pos = 0; cdb_res = 0;
    cdb_jump = 0; cdb_tgt = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input bit st,
                       input bit br, input bit pred);
    iss_en = 1; iss_rd = rd; iss_id = 6'(rd) + 6'd1;
    iss_st = st; iss_br = br; iss_pred = pred;
    tick();
    iss_en = 0;
  endtask

  task automatic cdb(input logic [3:0] p, input logic [31:0] r,
                     input bit j, input logic [31:0] t);
    cdb_en = 1; cdb_pos = p; cdb_res = r; cdb_jump = j; cdb_tgt = t;
    tick();
    cdb_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    nt++;
    if ({c_en, l_en, clr} !== 3'b000) begin
      nf++;
      $display("FAIL reset_pulses got %b want 000", {c_en, l_en, clr});
    end
    nt++;
    if (tail_pos !== 4'd1 || full !== 1'b0) begin
      nf++;
      $display("FAIL reset_tail got %0d/%b want 1/0", tail_pos, full);
    end
    nt++;
    if (jpc !== 0 || c_res !== 0 || c_pos !== 0 || c_rd !== 0) begin
      nf++;
      $display("FAIL reset_regs got %h/%h/%h want 0", jpc, c_res, c_pos);
    end
  endtask

  task automatic test_single_commit();
    do_reset();
    issue(5'd5, 0, 0, 0);
    cdb(4'd1, 32'h2A, 0, 0);
    nt++;
    if (c_en !== 1'b0) begin
      nf++;
      $display("FAIL single_early got %b want 0", c_en);
    end
    tick();
    nt++;
    if ({c_en, c_rd, c_pos, c_res} !== {1'b1, 5'd5, 4'd1, 32'h2A}) begin
      nf++;
      $display("FAIL single_commit got %b %0d %0d %h want 1 5 1 2a",
               c_en, c_rd, c_pos, c_res);
    end
    tick();
    nt++;
    if (c_en !== 1'b0 || tail_pos !== 4'd2 || full !== 1'b0) begin
      nf++;
      $display("FAIL single_after got %b %0d want 0 2", c_en, tail_pos);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      nt++;
      if (tail_pos !== 4'(i)) begin
        nf++;
        $display("FAIL wrap_tail got %0d want %0d", tail_pos, i);
      end
      issue(5'(i), 0, 0, 0);
    end
    nt++;
    if (full !== 1'b1 || tail_pos !== 4'd1) begin
      nf++;
      $display("FAIL full_flag got %b/%0d want 1/1", full, tail_pos);
    end
    issue(5'd20, 0, 0, 0);
    nt++;
    if (full !== 1'b1 || tail_pos !== 4'd1) begin
      nf++;
      $display("FAIL full_ignore got %b/%0d want 1/1", full, tail_pos);
    end
    cdb(4'd1, 32'h11, 0, 0);
    iss_en = 1; iss_rd = 5'd9;
    tick();
    iss_en = 0;
    nt++;
    if (c_en !== 1'b1 || full !== 1'b0 || tail_pos !== 4'd1) begin
      nf++;
      $display("FAIL full_commit got %b %b %0d want 1 0 1",
               c_en, full, tail_pos);
    end
    issue(5'd9, 0, 0, 0);
    nt++;
    if (full !== 1'b1 || tail_pos !== 4'd2) begin
      nf++;
      $display("FAIL wrap_realloc got %b/%0d want 1/2", full, tail_pos);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 1; i <= 3; i++) issue(5'(i + 10), 0, 0, 0);
    cdb(4'd3, 32'h33, 0, 0);
    cdb(4'd2, 32'h22, 0, 0);
    cdb(4'd1, 32'h11, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      nt++;
      if (c_en !== 1'b1 || c_pos !== 4'(i) ||
          c_res !== 32'(i * 32'h11)) begin
        nf++;
        $display("FAIL ooo_commit got %b %0d %h want 1 %0d %h",
                 c_en, c_pos, c_res, i, i * 32'h11);
      end
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    issue(5'd1, 0, 1, 0);
    issue(5'd2, 0, 0, 0);
    issue(5'd3, 0, 0, 0);
    cdb(4'd1, 32'h0, 1, 32'h100);
    tick();
    nt++;
    if ({c_en, clr, c_pos} !== {1'b1, 1'b1, 4'd1} || jpc !== 32'h100) begin
      nf++;
      $display("FAIL mispredict got %b %b %0d %h want 1 1 1 100",
               c_en, clr, c_pos, jpc);
    end
    nt++;
    if (tail_pos !== 4'd1 || full !== 1'b0) begin
      nf++;
      $display("FAIL flush_tail got %0d want 1", tail_pos);
    end
    cdb(4'd2, 32'h5, 0, 0);
    q1 = 4'd2;
    tick();
    nt++;
    if (c_en !== 1'b0 || clr !== 1'b0 || q1_rdy !== 1'b0) begin
      nf++;
      $display("FAIL flush_cdb got %b %b %b want 000", c_en, clr, q1_rdy);
    end
  endtask

  task automatic test_store_query();
    do_reset();
    iss_en = 1; iss_rd = 5'd7; iss_st = 1;
    tick();
    iss_en = 0; iss_st = 0;
    q1 = 4'd1; q2 = 4'd0;
    #1;
    nt++;
    if (q1_rdy !== 1'b1 || q2_rdy !== 1'b0) begin
      nf++;
      $display("FAIL store_query got %b/%b want 1/0", q1_rdy, q2_rdy);
    end
    tick();
    nt++;
    if ({l_en, l_pos, c_en} !== {1'b1, 4'd1, 1'b1}) begin
      nf++;
      $display("FAIL store_commit got %b %0d %b want 1 1 1",
               l_en, l_pos, c_en);
    end
  endtask

  task automatic test_stall();
    do_reset();
    issue(5'd4, 0, 0, 0);
    cdb(4'd1, 32'hBEEF, 0, 0);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nt++;
      if (c_en !== 1'b0 || tail_pos !== 4'd2) begin
        nf++;
        $display("FAIL stall_hold got %b/%0d want 0/2", c_en, tail_pos);
      end
    end
    rdy = 1;
    tick();
    nt++;
    if (c_en !== 1'b1 || c_res !== 32'hBEEF) begin
      nf++;
      $display("FAIL stall_resume got %b %h want 1 beef", c_en, c_res);
    end
    rdy = 0;
    tick();
    nt++;
    if (c_en !== 1'b1) begin
      nf++;
      $display("FAIL stall_pulse_hold got %b want 1", c_en);
    end
    rdy = 1;
  endtask

  task automatic test_random();
    bit          x_rdy;
    logic [31:0] x_res;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst      = ($urandom_range(0, 299) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      iss_en   = $urandom_range(0, 1);
      iss_rd   = 5'($urandom);
      iss_id   = 6'($urandom);
      iss_st   = ($urandom_range(0, 4) == 0);
      iss_br   = !iss_st && ($urandom_range(0, 5) == 0);
      iss_pred = $urandom_range(0, 1);
      cdb_en   = ($urandom_range(0, 9) < 7);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_pos = 4'(mq[$urandom_range(0, mq.size() - 1)].pos);
      else
        cdb_pos = 4'($urandom_range(0, 15));
      cdb_res  = $urandom;
      cdb_jump = $urandom_range(0, 1);
      cdb_tgt  = $urandom;
      q1       = 4'($urandom_range(0, 15));
      q2       = 4'($urandom_range(0, 15));
      #1;
      nt++;
      if (tail_pos !== 4'(m_tail) || full !== (mq.size() == 15)) begin
        nf++;
        $display("FAIL rnd_tail got %0d/%b want %0d/%b",
                 tail_pos, full, m_tail, mq.size() == 15);
      end
      x_rdy = 0; x_res = 0;
      foreach (mq[k]) begin
        if (mq[k].pos == int'(q1) && mq[k].done) begin
          x_rdy = 1; x_res = mq[k].res;
        end
      end
      nt++;
      if (q1_rdy !== x_rdy || (x_rdy && q1_res !== x_res)) begin
        nf++;
        $display("FAIL rnd_query pos %0d got %b %h want %b %h",
                 q1, q1_rdy, q1_res, x_rdy, x_res);
      end
      tick();
      nt++;
      if (c_en !== e_en || l_en !== e_lsb || clr !== e_clr) begin
        nf++;
        $display("FAIL rnd_pulses got %b%b%b want %b%b%b",
                 c_en, l_en, clr, e_en, e_lsb, e_clr);
      end
      nt++;
      if (c_id !== e_id || c_rd !== e_rd || c_pos !== e_pos ||
          c_res !== e_res || l_pos !== e_lsbpos || jpc !== e_jpc) begin
        nf++;
        $display("FAIL rnd_data got %h %h %h %h %h %h want %h %h %h %h %h %h",
                 c_id, c_rd, c_pos, c_res, l_pos, jpc,
                 e_id, e_rd, e_pos, e_res, e_lsbpos, e_jpc);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_commit();
    test_full_wrap();
    test_out_of_order();
    test_mispredict();
    test_store_query();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
